// File: rtl/hash_pkg.sv
// Shared definitions for the Jenkins hash key feeder: FSM encoding and default sizes.
package hash_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    WAIT = 2'd3
  } state_t;

  localparam int BLOCK_SIZE  = 12;
  localparam int DEF_MAXLEN  = 250;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/key_buf.sv
// Key byte store: one synchronous write port, one combinational read port.
module key_buf
  import hash_pkg::*;
#(
  parameter int DEPTH = DEF_MAXLEN
) (
  input  logic       CLK,
  input  logic       we,
  input  logic [7:0] widx,
  input  logic [7:0] wdata,
  input  logic [7:0] ridx,
  output logic [7:0] rdata
);

  localparam logic [7:0] DEPTH8 = 8'(DEPTH);

  logic [7:0] mem [DEPTH];

  // Store each accepted key byte at its write index; contents need no reset
  always_ff @(posedge CLK) begin
    if (we && (widx < DEPTH8)) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = (ridx < DEPTH8) ? mem[ridx] : 8'd0;

endmodule

// File: rtl/hash_key_feeder.sv
// Buffers one key from a byte stream, replays it as a contiguous burst to the
// hash core, then waits for the core's result before taking the next key.
module hash_key_feeder
  import hash_pkg::*;
#(
  parameter int MAXLEN  = DEF_MAXLEN,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int BLOCK   = BLOCK_SIZE
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       s_start,
  input  logic [7:0] s_len,
  input  logic [7:0] s_initval,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       enable,
  output logic [7:0] word,
  output logic [7:0] wcount,
  output logic       onloop,
  output logic [7:0] key_length,
  output logic [7:0] interval,
  input  logic       hash_valid,
  output logic       busy,
  output logic       err_len,
  output logic       err_timeout
);

  localparam logic [7:0] MAX_LEN8 = 8'(MAXLEN);
  localparam logic [7:0] BLOCK8   = 8'(BLOCK);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] widx;
  logic [7:0] ridx;
  logic [7:0] tcnt;
  logic [7:0] rd_data;
  logic [7:0] first_word;
  logic [7:0] remaining;
  logic       accept;
  logic       at_last;
  logic       len_ok;

  assign accept     = (state == LOAD) && s_valid && s_ready;
  assign at_last    = (widx == (key_length - 8'd1));
  assign len_ok     = (s_len != 8'd0) && (s_len <= MAX_LEN8);
  assign remaining  = key_length - ridx;
  // A one-byte key is still being written when the first word is launched
  assign first_word = (widx == 8'd0) ? s_data : rd_data;

  key_buf #(
    .DEPTH(MAXLEN)
  ) u_key_buf (
    .CLK  (CLK),
    .we   (accept),
    .widx (widx),
    .wdata(s_data),
    .ridx (ridx),
    .rdata(rd_data)
  );

  // Controller: load, replay and wait phases with all outputs registered
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      widx        <= 8'd0;
      ridx        <= 8'd0;
      tcnt        <= 8'd0;
      s_ready     <= 1'b0;
      enable      <= 1'b0;
      word        <= 8'd0;
      wcount      <= 8'd0;
      onloop      <= 1'b0;
      key_length  <= 8'd0;
      interval    <= 8'd0;
      busy        <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (s_start) begin
            if (len_ok) begin
              key_length <= s_len;
              interval   <= s_initval;
              widx       <= 8'd0;
              ridx       <= 8'd0;
              s_ready    <= 1'b1;
              busy       <= 1'b1;
              state      <= LOAD;
            end else begin
              err_len <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            widx <= widx + 8'd1;
            if (s_last && at_last) begin
              s_ready <= 1'b0;
              enable  <= 1'b1;
              word    <= first_word;
              wcount  <= key_length;
              onloop  <= (key_length > BLOCK8);
              ridx    <= 8'd1;
              state   <= EMIT;
            end else if (s_last || at_last) begin
              err_len    <= 1'b1;
              s_ready    <= 1'b0;
              busy       <= 1'b0;
              key_length <= 8'd0;
              interval   <= 8'd0;
              state      <= IDLE;
            end
          end
        end
        EMIT: begin
          if (ridx == key_length) begin
            enable <= 1'b0;
            word   <= 8'd0;
            wcount <= 8'd0;
            onloop <= 1'b0;
            tcnt   <= 8'd0;
            state  <= WAIT;
          end else begin
            word   <= rd_data;
            wcount <= remaining;
            onloop <= (remaining > BLOCK8);
            ridx   <= ridx + 8'd1;
          end
        end
        WAIT: begin
          if (hash_valid) begin
            key_length <= 8'd0;
            interval   <= 8'd0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (tcnt == TO_LAST) begin
            err_timeout <= 1'b1;
            key_length  <= 8'd0;
            interval    <= 8'd0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_key_feeder.sv
// Directed bench for hash_key_feeder: bursts, onloop boundary, errors, timeout, async reset.
module tb_hash_key_feeder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       s_start;
  logic [7:0] s_len;
  logic [7:0] s_initval;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       enable;
  logic [7:0] word;
  logic [7:0] wcount;
  logic       onloop;
  logic [7:0] key_length;
  logic [7:0] interval;
  logic       hash_valid;
  logic       busy;
  logic       err_len;
  logic       err_timeout;

  int passChecks  = 0;
  int totalChecks = 0;
  int rdy;
  int cnt;

  // Free-running clock, 10 ns period
  always #5 CLK = ~CLK;

  hash_key_feeder dut (
    .CLK        (CLK),
    .RST        (RST),
    .s_start    (s_start),
    .s_len      (s_len),
    .s_initval  (s_initval),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .enable     (enable),
    .word       (word),
    .wcount     (wcount),
    .onloop     (onloop),
    .key_length (key_length),
    .interval   (interval),
    .hash_valid (hash_valid),
    .busy       (busy),
    .err_len    (err_len),
    .err_timeout(err_timeout)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    totalChecks++;
    assert (observed === expected) passChecks++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic st, input logic [7:0] len, input logic [7:0] iv,
                               input logic v, input logic [7:0] d, input logic l, input logic hv);
    s_start    = st;
    s_len      = len;
    s_initval  = iv;
    s_valid    = v;
    s_data     = d;
    s_last     = l;
    hash_valid = hv;
  endtask

  // Start a key and stream its bytes; returns at the negedge after the last accepted byte
  task automatic loadKey(input int len, input logic [7:0] base, input int lastPos,
                         input bit gappy, output int rdyCycles);
    int sent;
    int cyc;
    int nbytes;
    nbytes = (lastPos != 0) ? lastPos : len;
    @(negedge CLK);
    applyStimulus(1'b1, 8'(len), 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    s_start   = 1'b0;
    sent      = 0;
    cyc       = 0;
    rdyCycles = 0;
    while ((sent < nbytes) && (cyc < 4 * len + 16)) begin
      if (s_ready) rdyCycles++;
      if (!gappy || (cyc % 2 == 0)) begin
        s_valid = 1'b1;
        s_data  = base + 8'(sent);
        s_last  = (sent + 1 == lastPos);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      if (s_valid && s_ready) sent++;
      cyc++;
      @(negedge CLK);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
    checkOutput("load_bytes_accepted", 16'(sent), 16'(nbytes));
  endtask

  // Observe the replay burst cycle by cycle; returns at the first WAIT cycle
  task automatic checkBurst(input int len, input logic [7:0] base, input int expOnloop);
    int enCnt;
    int olCnt;
    int wordErr;
    int wcErr;
    int olErr;
    int klErr;
    enCnt = 0; olCnt = 0; wordErr = 0; wcErr = 0; olErr = 0; klErr = 0;
    for (int i = 0; i < len; i++) begin
      if (enable) enCnt++;
      if (onloop) olCnt++;
      if (word !== base + 8'(i)) wordErr++;
      if (wcount !== 8'(len - i)) wcErr++;
      if (onloop !== ((len - i) > 12)) olErr++;
      if ((key_length !== 8'(len)) || (interval !== 8'h5A)) klErr++;
      @(negedge CLK);
    end
    checkOutput("burst_enable_cycles", 16'(enCnt), 16'(len));
    checkOutput("burst_word_errors", 16'(wordErr), 16'd0);
    checkOutput("burst_wcount_errors", 16'(wcErr), 16'd0);
    checkOutput("burst_onloop_cycles", 16'(olCnt), 16'(expOnloop));
    checkOutput("burst_onloop_errors", 16'(olErr), 16'd0);
    checkOutput("burst_keylen_interval_errors", 16'(klErr), 16'd0);
    checkOutput("post_burst_enable", 16'(enable), 16'd0);
    checkOutput("post_burst_wcount", 16'(wcount), 16'd0);
    checkOutput("post_burst_word", 16'(word), 16'd0);
    checkOutput("post_burst_onloop", 16'(onloop), 16'd0);
    checkOutput("post_burst_busy", 16'(busy), 16'd1);
  endtask

  // Answer from the core a few cycles into WAIT and confirm return to IDLE
  task automatic finishKey();
    @(negedge CLK);
    @(negedge CLK);
    hash_valid = 1'b1;
    @(negedge CLK);
    hash_valid = 1'b0;
    checkOutput("done_busy", 16'(busy), 16'd0);
    checkOutput("done_key_length", 16'(key_length), 16'd0);
    checkOutput("done_interval", 16'(interval), 16'd0);
  endtask

  task automatic badLen(input logic [7:0] len);
    @(negedge CLK);
    applyStimulus(1'b1, len, 8'h11, 1'b1, 8'hEE, 1'b0, 1'b0);
    @(negedge CLK);
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b1, 8'hEE, 1'b0, 1'b0);
    checkOutput("badlen_err_len", 16'(err_len), 16'd1);
    checkOutput("badlen_s_ready", 16'(s_ready), 16'd0);
    checkOutput("badlen_busy", 16'(busy), 16'd0);
    @(negedge CLK);
    s_valid = 1'b0;
    checkOutput("badlen_err_pulse_end", 16'(err_len), 16'd0);
  endtask

  // Hard stop in case the directed sequence stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    RST = 1'b1;
    applyStimulus(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    checkOutput("reset_s_ready", 16'(s_ready), 16'd0);
    checkOutput("reset_enable", 16'(enable), 16'd0);
    checkOutput("reset_word_wcount", {word, wcount}, 16'd0);
    checkOutput("reset_onloop_busy", {14'd0, onloop, busy}, 16'd0);
    checkOutput("reset_keylen_interval", {key_length, interval}, 16'd0);
    checkOutput("reset_errors", {14'd0, err_len, err_timeout}, 16'd0);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("idle_busy", 16'(busy), 16'd0);

    $display("[TB] test 1: len=15 continuous");
    loadKey(15, 8'h01, 15, 1'b0, rdy);
    checkOutput("t1_ready_cycles", 16'(rdy), 16'd15);
    checkOutput("t1_s_ready_drop", 16'(s_ready), 16'd0);
    checkBurst(15, 8'h01, 3);
    finishKey();

    $display("[TB] test 2: onloop boundary len=12/13/7");
    loadKey(12, 8'hA0, 12, 1'b0, rdy);
    checkBurst(12, 8'hA0, 0);
    finishKey();
    loadKey(13, 8'hC0, 13, 1'b0, rdy);
    checkBurst(13, 8'hC0, 1);
    finishKey();
    loadKey(7, 8'h30, 7, 1'b0, rdy);
    checkBurst(7, 8'h30, 0);
    finishKey();

    $display("[TB] test 3: len=250 with gaps");
    loadKey(250, 8'h01, 250, 1'b1, rdy);
    checkBurst(250, 8'h01, 238);
    finishKey();

    $display("[TB] test 4: framing and length errors");
    loadKey(7, 8'h40, 5, 1'b0, rdy);
    checkOutput("early_last_err_len", 16'(err_len), 16'd1);
    checkOutput("early_last_busy", 16'(busy), 16'd0);
    checkOutput("early_last_s_ready", 16'(s_ready), 16'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (enable) cnt++;
      @(negedge CLK);
    end
    checkOutput("early_last_no_enable", 16'(cnt), 16'd0);
    checkOutput("early_last_err_pulse_end", 16'(err_len), 16'd0);
    loadKey(7, 8'h40, 0, 1'b0, rdy);
    checkOutput("missing_last_err_len", 16'(err_len), 16'd1);
    checkOutput("missing_last_busy", 16'(busy), 16'd0);
    checkOutput("missing_last_enable", 16'(enable), 16'd0);
    badLen(8'd0);
    badLen(8'd251);

    $display("[TB] test 5: core timeout");
    loadKey(7, 8'h50, 7, 1'b0, rdy);
    checkBurst(7, 8'h50, 0);
    cnt = 0;
    while (!err_timeout && (cnt < 100)) begin
      @(negedge CLK);
      cnt++;
    end
    checkOutput("timeout_cycles", 16'(cnt), 16'd64);
    checkOutput("timeout_busy", 16'(busy), 16'd0);
    @(negedge CLK);
    checkOutput("timeout_pulse_end", 16'(err_timeout), 16'd0);
    loadKey(7, 8'h60, 7, 1'b0, rdy);
    checkBurst(7, 8'h60, 0);
    finishKey();

    $display("[TB] test 6: async reset mid-burst");
    loadKey(15, 8'h01, 15, 1'b0, rdy);
    repeat (6) @(negedge CLK);
    checkOutput("pre_reset_wcount", 16'(wcount), 16'd9);
    RST = 1'b1;
    #1;
    checkOutput("async_enable", 16'(enable), 16'd0);
    checkOutput("async_word_wcount", {word, wcount}, 16'd0);
    checkOutput("async_key_length", 16'(key_length), 16'd0);
    checkOutput("async_s_ready_busy", {14'd0, s_ready, busy}, 16'd0);
    @(negedge CLK);
    RST = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (enable || busy) cnt++;
      @(negedge CLK);
    end
    checkOutput("post_reset_quiet", 16'(cnt), 16'd0);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
